ram_scan_source: RTL and testbench



---
 rtl/ram_scan_source_pkg.sv | 14 +
 rtl/ram_scan_source_if.sv | 35 +++
 rtl/ram_scan_source_ram32x4.sv | 27 ++
 rtl/ram_scan_source.sv | 124 ++++++++++++
 tb/tb_ram_scan_source.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_scan_source_pkg.sv
// Shared widths and state type for the RAM scan source.
// Imported by the interface, the RAM and the top.
package ram_scan_source_pkg;

  localparam int ADDR_W_DFLT   = 5;
  localparam int DATA_W_DFLT   = 4;
  localparam int TICK_DIV_DFLT = 50_000_000;

  typedef enum logic {
    CLEAR,
    SCAN
  } state_t;

endpackage

// File: rtl/ram_scan_source_if.sv
// Switch/key inputs and display outputs of the RAM scan source.
// master drives the switches, slave is the scan source.
interface ram_scan_source_if
  import ram_scan_source_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
);

  logic              wr_key;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              busy;

  modport master (
    output wr_key,
    output wr_addr,
    output wr_data,
    input  disp_addr,
    input  disp_data,
    input  busy
  );

  modport slave (
    input  wr_key,
    input  wr_addr,
    input  wr_data,
    output disp_addr,
    output disp_data,
    output busy
  );

endinterface

// File: rtl/ram_scan_source_ram32x4.sv
// Simple dual-port RAM: synchronous write, registered read.
// Read and write of one address in one cycle returns the old word.
module ram32x4
  import ram_scan_source_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // No reset here so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_scan_source.sv
// Clears the RAM after reset, then scans it slowly for the display
// while accepting one write per key press from the switches.
module ram_scan_source
  import ram_scan_source_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DFLT,
  parameter int DATA_W   = DATA_W_DFLT,
  parameter int TICK_DIV = TICK_DIV_DFLT
) (
  input logic              clk,
  input logic              rst_n,
  ram_scan_source_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] clr_addr_q;
  logic [ADDR_W-1:0] scan_addr_q;
  logic [TW-1:0]     tick_q;
  logic [2:0]        sync_q;
  logic              wr_pulse;

  logic [ADDR_W-1:0] disp_addr_q;
  logic              disp_vld_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // sync_q[1:0] resynchronise the key, sync_q[2] is its previous value.
  assign wr_pulse = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], bus.wr_key};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_waddr = bus.wr_addr;
    ram_wdata = bus.wr_data;
    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        ram_wdata = '0;
        if (clr_addr_q == ADDR_LAST) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        ram_we = wr_pulse;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_addr_q <= clr_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q      <= '0;
      scan_addr_q <= '0;
    end else if (state_q == SCAN) begin
      if (tick_q == TICK_LAST) begin
        tick_q      <= '0;
        scan_addr_q <= scan_addr_q + ADDR_W'(1);
      end else begin
        tick_q <= tick_q + TW'(1);
      end
    end
  end

  // Address register lines up with the RAM's registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_addr_q <= '0;
      disp_vld_q  <= 1'b0;
    end else begin
      disp_addr_q <= (state_q == SCAN) ? scan_addr_q : '0;
      disp_vld_q  <= (state_q == SCAN);
    end
  end

  ram32x4 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (scan_addr_q),
    .rdata (ram_rdata)
  );

  assign bus.disp_addr = disp_addr_q;
  assign bus.disp_data = disp_vld_q ? ram_rdata : '0;
  assign bus.busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_scan_source.sv
// Bench for ram_scan_source: per-cycle reference model plus
// directed vectors for clear, write, wrap and reset corners.
module tb_ram_scan_source;

  localparam int AW    = 5;
  localparam int DW    = 4;
  localparam int TD    = 4;
  localparam int DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_scan_source_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_scan_source #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .TICK_DIV (TD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: edges counted from reset release, CLEAR owns
  // edges 1..DEPTH, a key edge sampled at edge e writes at edge e+2.
  logic [DW-1:0] mm [DEPTH];
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_busy = 1'b1;
  int  k = 0;
  bit  ks1 = 0, ks2 = 0, ks3 = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = 4'(i);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        k = 0; ks1 = 0; ks2 = 0; ks3 = 0;
        exp_addr = '0; exp_data = '0; exp_busy = 1'b1;
      end else begin
        bit pulse;
        int j;
        k++;
        pulse = ks2 && !ks3;
        ks3 = ks2; ks2 = ks1; ks1 = bus.wr_key;
        if (k <= DEPTH) begin
          mm[k-1]  = '0;
          exp_addr = '0;
          exp_data = '0;
          exp_busy = (k < DEPTH);
        end else begin
          j = k - DEPTH - 1;
          exp_addr = AW'((j / TD) % DEPTH);
          exp_data = mm[exp_addr];
          exp_busy = 1'b0;
          if (pulse) mm[bus.wr_addr] = bus.wr_data;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("sb_addr", int'(bus.disp_addr), int'(exp_addr));
      chk("sb_data", int'(bus.disp_data), int'(exp_data));
      chk("sb_busy", int'(bus.busy), int'(exp_busy));
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            hold;
    logic [DW-1:0] expect_d;
  } vec_t;

  vec_t vecs [5];

  task automatic press(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int hold);
    @(negedge clk);
    bus.wr_addr = a; bus.wr_data = d; bus.wr_key = 1'b1;
    for (int c = 1; c < hold; c++) begin
      @(negedge clk);
      if (c == 4) bus.wr_data = d ^ 4'hF;
    end
    @(negedge clk);
    bus.wr_key = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, input bit trans,
                           output bit ok);
    logic [AW-1:0] prev;
    ok = 0;
    prev = bus.disp_addr;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.disp_addr == a && (!trans || prev != a)) begin
        ok = 1;
        break;
      end
      prev = bus.disp_addr;
    end
  endtask

  initial begin
    int cnt;
    bit ok;
    logic [DW-1:0] acc;
    logic [AW-1:0] acca;
    bit seen;

    vecs[0] = '{5'd5,  4'hA, 10, 4'hA};
    vecs[1] = '{5'd17, 4'h3, 1,  4'h3};
    vecs[2] = '{5'd31, 4'hF, 6,  4'hF};
    vecs[3] = '{5'd0,  4'h9, 2,  4'h9};
    vecs[4] = '{5'd5,  4'h4, 3,  4'h4};

    bus.wr_key = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    #2 rst_n = 1'b0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_addr", int'(bus.disp_addr), 0);
    chk("rst_data", int'(bus.disp_data), 0);

    // Clear length and quiet outputs during CLEAR.
    rst_n = 1'b1;
    cnt = 0; acc = '0; acca = '0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      acc  |= bus.disp_data;
      acca |= bus.disp_addr;
      @(negedge clk);
    end
    chk("clear_len", cnt, 32);
    chk("clear_data0", int'(acc), 0);
    chk("clear_addr0", int'(acca), 0);

    acc = '0; cnt = 0;
    for (int c = 0; c < DEPTH * TD + 4; c++) begin
      @(negedge clk);
      acc |= bus.disp_data;
      if (bus.disp_addr == 5'd31) cnt++;
    end
    chk("sweep_zero", int'(acc), 0);
    chk("sweep_saw31", int'(cnt > 0), 1);

    for (int i = 0; i < 5; i++) begin
      press(vecs[i].addr, vecs[i].data, vecs[i].hold);
      wait_addr(vecs[i].addr, 1'b0, ok);
      chk("vec_found", int'(ok), 1);
      chk("vec_data", int'(bus.disp_data), int'(vecs[i].expect_d));
      if (i == 0) begin
        acc = '0; seen = 0;
        for (int c = 0; c < DEPTH * TD + 4; c++) begin
          @(negedge clk);
          if (bus.disp_addr != 5'd5) acc |= bus.disp_data;
          else seen |= (bus.disp_data == 4'hA);
        end
        chk("others_zero", int'(acc), 0);
        chk("addr5_is_A", int'(seen), 1);
      end
    end

    // Write to the displayed address: key first sampled on the
    // edge where disp_addr turns 3.
    wait_addr(5'd2, 1'b1, ok);
    chk("rdw_found2", int'(ok), 1);
    repeat (3) @(negedge clk);
    bus.wr_addr = 5'd3; bus.wr_data = 4'h7; bus.wr_key = 1'b1;
    @(negedge clk);
    chk("rdw_e0_addr", int'(bus.disp_addr), 3);
    chk("rdw_e0_data", int'(bus.disp_data), 0);
    repeat (2) @(negedge clk);
    chk("rdw_e2_old", int'(bus.disp_data), 0);
    @(negedge clk);
    chk("rdw_e3_new", int'(bus.disp_data), 7);
    chk("rdw_e3_addr", int'(bus.disp_addr), 3);
    bus.wr_key = 1'b0;

    // Wrap 31 -> 0.
    wait_addr(5'd31, 1'b1, ok);
    chk("wrap_found31", int'(ok), 1);
    cnt = 0;
    while (bus.disp_addr == 5'd31 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("wrap_period", cnt, 4);
    chk("wrap_addr0", int'(bus.disp_addr), 0);
    chk("wrap_data0", int'(bus.disp_data), 9);

    // Key held through a mid-scan reset asserted between edges.
    wait_addr(5'd5, 1'b0, ok);
    chk("hold_found5", int'(ok), 1);
    bus.wr_addr = 5'd5; bus.wr_data = 4'hC; bus.wr_key = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_addr", int'(bus.disp_addr), 0);
    chk("async_data", int'(bus.disp_data), 0);
    chk("async_busy", int'(bus.busy), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("hold_clear_done", int'(bus.busy), 0);
    wait_addr(5'd5, 1'b0, ok);
    chk("hold_found5b", int'(ok), 1);
    chk("held_no_write", int'(bus.disp_data), 0);
    bus.wr_key = 1'b0;

    // Random key presses checked by the model.
    for (int r = 0; r < 30; r++) begin
      press(AW'($urandom_range(0, DEPTH - 1)),
            DW'($urandom_range(0, 15)),
            int'($urandom_range(1, 6)));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    repeat (DEPTH * TD + 8) @(negedge clk);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
